// File: rtl/branch_resolve_predict.sv
// branch_resolve_predict
//   EX-stage branch/jump resolution unit with a PC-indexed table of 2-bit
//   saturating counters. IF reads the table combinationally for a
//   prediction. EX trains it on each resolved conditional branch and flags
//   mispredictions.
//
//   Optional feature macro: BPRED_STATS_EN
//     defined   -> BranchCount / MispredCount are live saturating counters
//     undefined -> both ports are tied to 0 and no counter registers exist
//
// Ports
//   Clk            rising-edge clock
//   Reset          asynchronous, active-high reset
//   PredPC         IF-stage PC for lookup
//   PredTaken      prediction for PredPC (combinational from table state)
//   ResValid       EX instruction valid this cycle
//   Flush          discard the current EX instruction
//   ResPC          PC of the EX instruction
//   Op             branch op (001 beq, 010 bne, 100 bgez/bltz, 101 bgtz,
//                  110 blez, 011 j, 000 R-type)
//   BGE_BLT        rt field; bit0 selects bgez (1) or bltz (0)
//   Funct          R-type funct; 001000 is jr
//   A, B           rs / rt operands
//   PredictedTaken prediction that IF made for this instruction
//   BranchAndJump  registered: 00 none, 01 cond taken, 10 j, 11 jr
//   Mispredict     registered one-cycle pulse
//   BranchCount    resolved conditional branches
//   MispredCount   mispredicted conditional branches
module branch_resolve_predict #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 64
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [PC_W-1:0]   PredPC,
  output logic              PredTaken,
  input  logic              ResValid,
  input  logic              Flush,
  input  logic [PC_W-1:0]   ResPC,
  input  logic [2:0]        Op,
  input  logic [4:0]        BGE_BLT,
  input  logic [5:0]        Funct,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              PredictedTaken,
  output logic [1:0]        BranchAndJump,
  output logic              Mispredict,
  output logic [31:0]       BranchCount,
  output logic [31:0]       MispredCount
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_BEQ   = 3'b001;
  localparam logic [2:0] OP_BNE   = 3'b010;
  localparam logic [2:0] OP_J     = 3'b011;
  localparam logic [2:0] OP_BGEZ  = 3'b100;
  localparam logic [2:0] OP_BGTZ  = 3'b101;
  localparam logic [2:0] OP_BLEZ  = 3'b110;
  localparam logic [5:0] FN_JR    = 6'b001000;

  function automatic logic [1:0] sat_inc2(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec2(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] res_idx;

  logic              is_cond;
  logic              cond_taken;
  logic              is_j;
  logic              is_jr;
  logic              a_neg;
  logic              a_zero;
  logic              res_fire;
  logic              upd;
  logic [1:0]        bj_next;
  logic              mis_next;

  logic [1:0]        bj_p1;
  logic              mis_p1;

  // Word-aligned PCs: drop the byte offset, alias modulo the table depth.
  assign pred_idx  = PredPC[IDX_W+1:2];
  assign res_idx   = ResPC[IDX_W+1:2];
  // Array read sees pre-update state, giving read-during-write old data.
  assign PredTaken = bht[pred_idx][1];

  assign a_neg  = A[DATA_W-1];
  assign a_zero = (A == '0);

  always_comb begin
    is_cond    = 1'b0;
    cond_taken = 1'b0;
    is_j       = 1'b0;
    is_jr      = 1'b0;
    case (Op)
      OP_BEQ:   begin is_cond = 1'b1; cond_taken = (A == B);               end
      OP_BNE:   begin is_cond = 1'b1; cond_taken = (A != B);               end
      OP_BGEZ:  begin is_cond = 1'b1; cond_taken = a_neg ^ BGE_BLT[0];     end
      OP_BGTZ:  begin is_cond = 1'b1; cond_taken = !a_neg && !a_zero;      end
      OP_BLEZ:  begin is_cond = 1'b1; cond_taken = a_neg || a_zero;        end
      OP_J:     is_j  = 1'b1;
      OP_RTYPE: is_jr = (Funct == FN_JR);
      default:  ;
    endcase
  end

  assign res_fire = ResValid && !Flush;
  assign upd      = res_fire && is_cond;
  assign bj_next  = (is_cond && cond_taken) ? 2'b01 :
                    is_j                    ? 2'b10 :
                    is_jr                   ? 2'b11 : 2'b00;
  assign mis_next = is_cond && (cond_taken != PredictedTaken);

  // ---- stage p1: registered resolution and table training ----
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
      bj_p1  <= 2'b00;
      mis_p1 <= 1'b0;
    end else begin
      bj_p1  <= res_fire ? bj_next : 2'b00;
      mis_p1 <= res_fire && mis_next;
      if (upd)
        bht[res_idx] <= cond_taken ? sat_inc2(bht[res_idx]) : sat_dec2(bht[res_idx]);
    end
  end

  assign BranchAndJump = bj_p1;
  assign Mispredict    = mis_p1;

`ifdef BPRED_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  logic [31:0] bcnt_p1;
  logic [31:0] mcnt_p1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bcnt_p1 <= '0;
      mcnt_p1 <= '0;
    end else if (upd) begin
      bcnt_p1 <= sat_inc32(bcnt_p1);
      if (mis_next) mcnt_p1 <= sat_inc32(mcnt_p1);
    end
  end

  assign BranchCount  = bcnt_p1;
  assign MispredCount = mcnt_p1;
`else
  assign BranchCount  = '0;
  assign MispredCount = '0;
`endif

  logic unused_bits;
  assign unused_bits = ^{PredPC[PC_W-1:IDX_W+2], PredPC[1:0],
                         ResPC[PC_W-1:IDX_W+2], ResPC[1:0], BGE_BLT[4:1]};

endmodule

// File: doc/branch_resolve_predict.md
Name: branch_resolve_predict

Overview:
- Next-generation branch/jump resolution unit for the MIPS datapath; sits at the EX stage.
- Evaluates beq/bne/bgez/bltz/bgtz/blez/j/jr with DATA_W-wide operands and registers the result.
- Owns a PC-indexed table of 2-bit saturating counters. IF reads it combinationally for a prediction; EX trains it on each resolved conditional branch.
- Flags mispredictions so hazard logic can flush.

Parameters:
DATA_W, 32, operand width of A/B; sign bit is A[DATA_W-1]
PC_W, 32, program-counter width
BHT_DEPTH, 64, counter-table entries; power of two, >= 2
IDX_W, $clog2(BHT_DEPTH), table index width (derived, not overridden)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
PredPC  in  PC_W  IF-stage PC for lookup
PredTaken  out  1  prediction for PredPC (combinational from table state)
ResValid  in  1  EX-stage instruction valid this cycle
Flush  in  1  discard the current EX instruction
ResPC  in  PC_W  PC of EX instruction
Op  in  3  branch op: 100 bgez/bltz, 001 beq, 010 bne, 101 bgtz, 110 blez, 011 j, 000 R-type
BGE_BLT  in  5  rt field; bit0=1 bgez, bit0=0 bltz
Funct  in  6  R-type funct; 001000 = jr
A  in  DATA_W  rs operand
B  in  DATA_W  rt operand
PredictedTaken  in  1  prediction that IF made for this instruction
BranchAndJump  out  2  registered: 00 none, 01 cond taken, 10 j, 11 jr
Mispredict  out  1  registered one-cycle pulse
BranchCount  out  32  resolved conditional branches (stats)
MispredCount  out  32  mispredicted conditional branches (stats)

Behaviour:
- Reset (async, any cycle, including mid-resolution):
  - BranchAndJump=00, Mispredict=0.
  - All table entries set to 01 (weakly not-taken).
  - BranchCount=MispredCount=0.
  - ResValid is ignored while Reset is high.
- Conditions (combinational, width-generic):
  - beq: A==B. bne: A!=B.
  - bgez/bltz: A[DATA_W-1] ^ BGE_BLT[0].
  - bgtz: !A[DATA_W-1] && A!=0.
  - blez: A[DATA_W-1] || A==0.
  - Any other Op/Funct combination is non-branch.
- Latency: one cycle. Inputs are sampled at posedge N; outputs are valid after posedge N until posedge N+1.
- Outputs are single-cycle pulses. If ResValid=0 or Flush=1 at an edge, the next BranchAndJump=00 and Mispredict=0.
- BranchAndJump codes:
  - Conditional branch: 01 if taken, else 00.
  - j: 10.
  - Op=000 with Funct=001000: 11.
  - Op=000 with any other Funct: 00.
- Mispredict = conditional branch && (taken != PredictedTaken). It is always 0 for j, jr and non-branches.
- Table index = PC[IDX_W+1:2]. Word-aligned PCs alias modulo BHT_DEPTH.
- PredTaken = entry[PredPC index][1].
- Update: on posedge with ResValid && !Flush && conditional branch.
  - Taken: counter+1, saturating at 11.
  - Not taken: counter-1, saturating at 00.
  - j, jr and non-branches never touch the table.
- Read-during-write: if PredPC and ResPC map to the same index in one cycle, PredTaken returns the pre-update value. The new value is visible from the next cycle.
- Flush && ResValid together: the resolution is discarded entirely. No table update, no counter increment, outputs 00/0.
- Counters (stats): each saturates at 0xFFFFFFFF; no wrap.

Optional Feature:
BPRED_STATS_EN
- Defined: BranchCount increments on every table update. MispredCount increments when that update also raises Mispredict.
- Undefined: both ports remain but are tied to 0, and no counter registers are synthesised.

Test Plan:
1. Reset: assert Reset for 3 cycles mid-stream with ResValid=1.
   -> BranchAndJump=00, Mispredict=0 throughout; PredTaken=0 for PredPC=0x00400010 and 0x004000FC.
2. Taken beq, mispredicted: A=B=0x12345678, ResPC=0x00400010, PredictedTaken=0, ResValid=1 for one cycle.
   -> Next cycle BranchAndJump=01, Mispredict=1, entry 4 = 10, PredTaken(0x00400010)=1.
   -> Following cycle outputs return to 00/0.
3. Saturation: four taken beq at 0x00400010 -> entry 11. One bne with A=B (not taken) -> 10, PredTaken=1. Three more not-taken -> 01, 00, 00, PredTaken=0.
4. Signed conditions, each predicted 0:
   - bltz, A=0x80000000, BGE_BLT=00000 -> 01, Mispredict=1.
   - bgez, same A, BGE_BLT=00001 -> 00, Mispredict=0.
   - bgtz, A=0 -> 00.
   - blez, A=0 -> 01.
5. Jumps:
   - Op=011 -> 10, Mispredict=0, table unchanged.
   - Op=000, Funct=001000 -> 11.
   - Op=000, Funct=100000 -> 00.
6. Flush and aliasing:
   - Taken beq at ResPC=0x00400110 with Flush=1 -> outputs 00/0, entry 4 unchanged.
   - Same beq without Flush -> PredTaken(0x00400010) reflects the update (shared entry 4).
   - With BPRED_STATS_EN: BranchCount rises by exactly 1 across the flushed and unflushed pair.
